// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, position counters, blanking, sync
// and data-enable for one video clock, with a frame-synchronous choice
// between 15 kHz (pixel every other clock) and 31 kHz (line-doubled) output.
module video_timing_gen #(
    parameter int H_ACTIVE = 550,
    parameter int H_FP     = 29,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 29,
    parameter int V_ACTIVE = 301,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 3,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic          CLK_VIDEO,
    input  logic          RESET,
    input  logic          enable,
    input  logic          scandouble,
    output logic          ce_pix,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic [VW-1:0] line,
    output logic          sd_mode,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic          DE,
    output logic          sof,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_STOP  = HW'(H_ACTIVE + H_FP + H_SYNC);

    // Vertical thresholds for both modes; index 1 is the line-doubled raster.
    logic [VW-1:0] v_last_tbl  [2];
    logic [VW-1:0] v_act_tbl   [2];
    logic [VW-1:0] vs_start_tbl[2];
    logic [VW-1:0] vs_stop_tbl [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vmode
            assign v_last_tbl[gi]   = VW'((V_TOTAL << gi) - 1);
            assign v_act_tbl[gi]    = VW'(V_ACTIVE << gi);
            assign vs_start_tbl[gi] = VW'((V_ACTIVE + V_FP) << gi);
            assign vs_stop_tbl[gi]  = VW'((V_ACTIVE + V_FP + V_SYNC) << gi);
        end
    endgenerate

    logic          ce_pix_reg, ce_pix_next;
    logic          phase_reg, phase_next;
    logic [HW-1:0] hc_reg, hc_next;
    logic [VW-1:0] vc_reg, vc_next;
    logic [VW-1:0] line_reg, line_next;
    logic          sd_mode_reg, sd_mode_next;
    logic [7:0]    frame_cnt_reg, frame_cnt_next;
    logic          sof_reg, sof_next;
    logic          hblank_reg, hblank_next;
    logic          vblank_reg, vblank_next;
    logic          hsync_reg, hsync_next;
    logic          vsync_reg, vsync_next;
    logic          de_reg, de_next;

    logic advance;
    logic h_wrap;
    logic v_wrap;
    logic frame_wrap;

    // A pixel step needs both the registered enable and the live enable, so a
    // falling enable suppresses a step that was already scheduled.
    assign advance    = ce_pix_reg & enable;
    assign h_wrap     = (hc_reg == H_LAST);
    assign v_wrap     = (vc_reg == v_last_tbl[sd_mode_reg]);
    assign frame_wrap = advance & h_wrap & v_wrap;

    // Next-state for counters, mode latch and frame counter.
    always_comb begin
        hc_next        = hc_reg;
        vc_next        = vc_reg;
        sd_mode_next   = sd_mode_reg;
        frame_cnt_next = frame_cnt_reg;
        if (advance) begin
            if (h_wrap) begin
                hc_next = '0;
                if (v_wrap) begin
                    vc_next        = '0;
                    sd_mode_next   = scandouble;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                end else begin
                    vc_next = vc_reg + 1'b1;
                end
            end else begin
                hc_next = hc_reg + 1'b1;
            end
        end
    end

    // Pixel cadence: phase alternates in 15 kHz mode and parks at 0 in
    // 31 kHz mode, so returning to 15 kHz starts with a low half-pixel.
    always_comb begin
        ce_pix_next = enable & (sd_mode_next | phase_reg);
        phase_next  = enable ? (~sd_mode_next & ~phase_reg) : phase_reg;
    end

    // Flags decoded from the upcoming position so they register alongside it.
    always_comb begin
        hblank_next = (hc_next >= H_ACT);
        vblank_next = (vc_next >= v_act_tbl[sd_mode_next]);
        hsync_next  = ((hc_next >= HS_START) && (hc_next < HS_STOP)) ? HS_POL : ~HS_POL;
        vsync_next  = ((vc_next >= vs_start_tbl[sd_mode_next]) &&
                       (vc_next <  vs_stop_tbl[sd_mode_next])) ? VS_POL : ~VS_POL;
        de_next     = ~(hblank_next | vblank_next);
        line_next   = vc_next >> sd_mode_next;
        sof_next    = frame_wrap;
    end

    // Position, mode and frame-count state.
    always_ff @(posedge CLK_VIDEO or posedge RESET) begin
        if (RESET) begin
            hc_reg        <= '0;
            vc_reg        <= '0;
            line_reg      <= '0;
            sd_mode_reg   <= 1'b0;
            frame_cnt_reg <= 8'd0;
            sof_reg       <= 1'b0;
        end else begin
            hc_reg        <= hc_next;
            vc_reg        <= vc_next;
            line_reg      <= line_next;
            sd_mode_reg   <= sd_mode_next;
            frame_cnt_reg <= frame_cnt_next;
            sof_reg       <= sof_next;
        end
    end

    // Pixel clock enable and its half-pixel phase.
    always_ff @(posedge CLK_VIDEO or posedge RESET) begin
        if (RESET) begin
            ce_pix_reg <= 1'b0;
            phase_reg  <= 1'b0;
        end else begin
            ce_pix_reg <= ce_pix_next;
            phase_reg  <= phase_next;
        end
    end

    // Registered blanking, sync and data-enable flags.
    always_ff @(posedge CLK_VIDEO or posedge RESET) begin
        if (RESET) begin
            hblank_reg <= 1'b0;
            vblank_reg <= 1'b0;
            hsync_reg  <= ~HS_POL;
            vsync_reg  <= ~VS_POL;
            de_reg     <= 1'b1;
        end else begin
            hblank_reg <= hblank_next;
            vblank_reg <= vblank_next;
            hsync_reg  <= hsync_next;
            vsync_reg  <= vsync_next;
            de_reg     <= de_next;
        end
    end

    assign ce_pix    = ce_pix_reg;
    assign hc        = hc_reg;
    assign vc        = vc_reg;
    assign line      = line_reg;
    assign sd_mode   = sd_mode_reg;
    assign frame_cnt = frame_cnt_reg;
    assign sof       = sof_reg;
    assign HBlank    = hblank_reg;
    assign VBlank    = vblank_reg;
    assign HSync     = hsync_reg;
    assign VSync     = vsync_reg;
    assign DE        = de_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (32 x 16 base geometry)
// with a position-level reference model checked on every clock.
module tb_video_timing_gen;

    localparam int HA = 20, HF = 3, HSW = 4, HBP = 5;
    localparam int VA = 10, VF = 2, VSW = 2, VBP = 2;
    localparam int HT = HA + HF + HSW + HBP;   // 32
    localparam int VT = VA + VF + VSW + VBP;   // 16
    localparam int HW = 6, VW = 6;
    localparam bit HSP = 1'b0, VSP = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic scandouble = 1'b0;

    logic          ce_pix, sd_mode, HBlank, VBlank, HSync, VSync, DE, sof;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc, line;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
        .HW(HW), .VW(VW), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .CLK_VIDEO(clk), .RESET(rst), .enable(enable), .scandouble(scandouble),
        .ce_pix(ce_pix), .hc(hc), .vc(vc), .line(line), .sd_mode(sd_mode),
        .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
        .DE(DE), .sof(sof), .frame_cnt(frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position, mode in force, frame number and
    // the pixel-enable cadence, stepped on each clock edge.
    int m_hc = 0, m_vc = 0, m_mode = 0, m_fc = 0, m_ce = 0, m_sof = 0;
    int m_since_pix = 0;   // enabled edges since ce_pix was last high (reset counts)
    bit m_step;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_hc = 0; m_vc = 0; m_mode = 0; m_fc = 0; m_ce = 0; m_sof = 0;
            m_since_pix = 0;
        end else begin
            m_step = (m_ce != 0) && enable;
            m_sof  = 0;
            if (m_step) begin
                if (m_hc == HT - 1) begin
                    m_hc = 0;
                    if (m_vc == (VT << m_mode) - 1) begin
                        m_vc   = 0;
                        m_mode = scandouble ? 1 : 0;
                        m_fc   = (m_fc + 1) % 256;
                        m_sof  = 1;
                    end else begin
                        m_vc = m_vc + 1;
                    end
                end else begin
                    m_hc = m_hc + 1;
                end
            end
            if (!enable) begin
                m_ce = 0;
            end else if (m_mode == 1) begin
                m_ce = 1;
                m_since_pix = 0;
            end else begin
                m_since_pix = m_since_pix + 1;
                m_ce = (m_since_pix == 2) ? 1 : 0;
                if (m_ce == 1) m_since_pix = 0;
            end
        end
    end

    // Per-mode observed ranges of the decoded flags, checked at the end.
    int hs_min[2] = '{999, 999}, hs_max[2] = '{-1, -1}, hb_min[2] = '{999, 999};
    int vb_min[2] = '{999, 999}, vs_min[2] = '{999, 999}, vs_max[2] = '{-1, -1};
    int vc_max[2] = '{-1, -1};

    logic       e_hb, e_vb, e_hs, e_vs, e_de;
    logic [33:0] exp_v, act_v;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        e_hb  = (m_hc >= HA);
        e_vb  = (m_vc >= (VA << m_mode));
        e_hs  = (m_hc >= HA + HF && m_hc < HA + HF + HSW) ? HSP : !HSP;
        e_vs  = (m_vc >= ((VA + VF) << m_mode) && m_vc < ((VA + VF + VSW) << m_mode)) ? VSP : !VSP;
        e_de  = !(e_hb || e_vb);
        exp_v = {m_ce[0], 6'(m_hc), 6'(m_vc), 6'(m_vc >> m_mode), m_mode[0],
                 e_hb, e_vb, e_hs, e_vs, e_de, m_sof[0], 8'(m_fc)};
        act_v = {ce_pix, hc, vc, line, sd_mode, HBlank, VBlank, HSync, VSync, DE, sof, frame_cnt};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs{ce,hc,vc,line,sd,hb,vb,hs,vs,de,sof,fc}: got %h, required %h (model hc=%0d vc=%0d, t=%0t)",
                     act_v, exp_v, m_hc, m_vc, $time);
        end
        if (!rst) begin
            if (HSync === HSP) begin
                if (int'(hc) < hs_min[m_mode]) hs_min[m_mode] = int'(hc);
                if (int'(hc) > hs_max[m_mode]) hs_max[m_mode] = int'(hc);
            end
            if (HBlank === 1'b1 && int'(hc) < hb_min[m_mode]) hb_min[m_mode] = int'(hc);
            if (VBlank === 1'b1 && int'(vc) < vb_min[m_mode]) vb_min[m_mode] = int'(vc);
            if (VSync === VSP) begin
                if (int'(vc) < vs_min[m_mode]) vs_min[m_mode] = int'(vc);
                if (int'(vc) > vs_max[m_mode]) vs_max[m_mode] = int'(vc);
            end
            if (int'(vc) > vc_max[m_mode]) vc_max[m_mode] = int'(vc);
        end
        if (sof === 1'b1)
            $display("frame start: frame_cnt=%0d sd_mode=%0d t=%0t", frame_cnt, sd_mode, $time);
    end

    // Count samples until sof; n = -1 if the budget runs out.
    task automatic wait_sof(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (sof === 1'b1) return;
        end
        n = -1;
    endtask

    int n, zeros, off, viol, found, hold;
    bit toggled;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_hc", hc, 0);
        check("rst_vc", vc, 0);
        check("rst_ce_pix", ce_pix, 0);
        check("rst_de", DE, 1);
        check("rst_hsync", HSync, 1);
        check("rst_vsync", VSync, 0);
        rst = 1'b0;

        // Pixel enable sequence 0,1,0,1 after release.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("ce_seq_%0d", i), ce_pix, (i % 2 == 0) ? 1 : 0);
        end

        // Two 15 kHz frames: first sof on clock 1025, then every 1024 clocks.
        wait_sof(1200, n);
        check("first_sof_clock", n + 4, 1025);
        check("frame_cnt_1", frame_cnt, 1);
        wait_sof(1200, n);
        check("sof_gap_15k", n, 1024);
        check("frame_cnt_2", frame_cnt, 2);

        // Request 31 kHz; it takes effect only at the next wrap.
        scandouble = 1'b1;
        wait_sof(1200, n);
        check("sof_gap_to_31k", n, 1024);
        check("sd_mode_after_wrap", sd_mode, 1);

        // 31 kHz frame; drop the request mid-frame at vc=10.
        zeros = 0; off = 0; toggled = 0; n = 0;
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (sof === 1'b1) break;
            if (ce_pix !== 1'b1) zeros++;
            if (sd_mode !== 1'b1) off++;
            if (!toggled && vc == 10) begin scandouble = 1'b0; toggled = 1; end
        end
        check("sof_gap_31k", n, 1024);
        check("ce_low_in_31k", zeros, 0);
        check("mode_changed_midframe_31k", off, 0);
        check("sd_mode_back_15k", sd_mode, 0);
        check("frame_cnt_4", frame_cnt, 4);

        // 15 kHz frame; request 31 kHz again at vc=5.
        off = 0; toggled = 0; n = 0;
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (sof === 1'b1) break;
            if (sd_mode !== 1'b0) off++;
            if (!toggled && vc == 5) begin scandouble = 1'b1; toggled = 1; end
        end
        check("sof_gap_15k_b", n, 1024);
        check("mode_changed_midframe_15k", off, 0);
        check("sd_mode_31k_again", sd_mode, 1);

        // Freeze enable on the last pixel of the 32-line frame.
        found = 0;
        for (int t = 0; t < 1100; t++) begin
            @(negedge clk);
            if (hc == HT - 1 && vc == 2 * VT - 1 && ce_pix === 1'b1) begin found = 1; break; end
        end
        check("reach_last_pixel", found, 1);
        enable = 1'b0;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (hc != HT - 1 || ce_pix !== 1'b0 || sof !== 1'b0) viol++;
        end
        check("freeze_violations", viol, 0);
        enable = 1'b1;
        wait_sof(10, n);
        check("resume_wrap_latency", n, 2);
        check("resume_hc", hc, 0);
        check("resume_vc", vc, 0);
        check("frame_cnt_6", frame_cnt, 6);

        // Asynchronous reset between edges at hc=10, vc=3.
        found = 0;
        for (int t = 0; t < 1100; t++) begin
            @(negedge clk);
            if (hc == 10 && vc == 3) begin found = 1; break; end
        end
        check("reach_mid_frame", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hc", hc, 0);
        check("async_rst_vc", vc, 0);
        check("async_rst_line", line, 0);
        check("async_rst_ce", ce_pix, 0);
        check("async_rst_sd_mode", sd_mode, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        check("async_rst_de", DE, 1);
        check("async_rst_hsync", HSync, 1);
        check("async_rst_vsync", VSync, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_hc", hc, 4);
        check("post_rst_frame_cnt", frame_cnt, 0);

        // Randomized mode requests and enable gaps.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) scandouble = ~scandouble;
            if ($urandom_range(0, 59) == 0) begin
                enable = 1'b0;
                hold = $urandom_range(1, 12);
                repeat (hold) @(negedge clk);
                enable = 1'b1;
            end
        end

        // Decoded flag ranges seen over the whole run.
        check("hblank_start_15k", hb_min[0], 20);
        check("hblank_start_31k", hb_min[1], 20);
        check("hsync_first_15k", hs_min[0], 23);
        check("hsync_last_15k", hs_max[0], 26);
        check("hsync_first_31k", hs_min[1], 23);
        check("hsync_last_31k", hs_max[1], 26);
        check("vc_max_15k", vc_max[0], 15);
        check("vc_max_31k", vc_max[1], 31);
        check("vblank_start_15k", vb_min[0], 10);
        check("vblank_start_31k", vb_min[1], 20);
        check("vsync_first_15k", vs_min[0], 12);
        check("vsync_last_15k", vs_max[0], 13);
        check("vsync_first_31k", vs_min[1], 24);
        check("vsync_last_31k", vs_max[1], 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
